// File: rtl/branch_predictor_bht_if.sv
// Fetch/execute-side bus of the branch predictor.
//   master : pipeline side  - drives PCF and the execute-stage resolution signals
//   slave  : predictor side - returns the fetch prediction and performance counters
interface branch_predictor_bht_if;
    logic [31:0] PCF;
    logic        PredictTakenF;
    logic [31:0] PredictTargetF;
    logic        UpdateE;
    logic [31:0] PCE;
    logic        TakenE;
    logic [31:0] TargetE;
    logic        MispredictE;
    logic [31:0] BranchCount;
    logic [31:0] MispredictCount;

    modport master (
        output PCF, UpdateE, PCE, TakenE, TargetE, MispredictE,
        input  PredictTakenF, PredictTargetF, BranchCount, MispredictCount
    );

    modport slave (
        input  PCF, UpdateE, PCE, TakenE, TargetE, MispredictE,
        output PredictTakenF, PredictTargetF, BranchCount, MispredictCount
    );
endinterface

// File: rtl/branch_predictor_bht.sv
// Direct-mapped BTB with a 2-bit saturating direction counter per entry.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset
//   bus  - slave modport of branch_predictor_bht_if:
//          PCF -> PredictTakenF/PredictTargetF (combinational lookup, no bypass)
//          UpdateE/PCE/TakenE/TargetE/MispredictE -> table training on posedge
//          BranchCount/MispredictCount -> wrapping performance counters
module branch_predictor_bht #(
    parameter int unsigned IDX_W    = 6,
    parameter int unsigned TAG_W    = 8,
    parameter logic [1:0]  CNT_INIT = 2'b01
) (
    input logic                    clk,
    input logic                    rst,
    branch_predictor_bht_if.slave  bus
);
    localparam int Entries = 2 ** IDX_W;
    localparam int TagLo   = IDX_W + 2;
    localparam int TagHi   = IDX_W + TAG_W + 1;

    localparam logic [1:0] CntWnt = 2'b01;
    localparam logic [1:0] CntWt  = 2'b10;

    logic [Entries-1:0] validQ;
    logic [TAG_W-1:0]   tagQ    [Entries];
    logic [31:0]        targetQ [Entries];
    logic [1:0]         cntQ    [Entries];
    logic [31:0]        branchCountQ;
    logic [31:0]        mispredictCountQ;

    // Fetch-side lookup
    logic [IDX_W-1:0] idxF;
    logic [TAG_W-1:0] tagF;
    logic             hitF;

    assign idxF = bus.PCF[IDX_W+1:2];
    assign tagF = bus.PCF[TagHi:TagLo];
    assign hitF = validQ[idxF] && (tagQ[idxF] == tagF);

    assign bus.PredictTakenF   = hitF & cntQ[idxF][1];
    assign bus.PredictTargetF  = hitF ? targetQ[idxF] : 32'h0;
    assign bus.BranchCount     = branchCountQ;
    assign bus.MispredictCount = mispredictCountQ;

    // Execute-side next-state for the addressed entry
    logic [IDX_W-1:0] idxE;
    logic [TAG_W-1:0] tagE;
    logic             hitE;
    logic [1:0]       cntNext;
    logic             writeTarget;

    assign idxE = bus.PCE[IDX_W+1:2];
    assign tagE = bus.PCE[TagHi:TagLo];
    assign hitE = validQ[idxE] && (tagQ[idxE] == tagE);

    always_comb begin
        cntNext     = cntQ[idxE];
        writeTarget = 1'b1;
        if (!hitE) begin
            // Fresh allocation starts weak in the observed direction
            cntNext = bus.TakenE ? CntWt : CntWnt;
        end else if (bus.TakenE) begin
            writeTarget = 1'b1;
            if (cntQ[idxE] != 2'b11) begin
                cntNext = cntQ[idxE] + 2'b01;
            end
        end else begin
            // A not-taken resolution carries no useful target
            writeTarget = 1'b0;
            if (cntQ[idxE] != 2'b00) begin
                cntNext = cntQ[idxE] - 2'b01;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            validQ <= '0;
            for (int i = 0; i < Entries; i++) begin
                tagQ[i]    <= '0;
                targetQ[i] <= '0;
                cntQ[i]    <= CNT_INIT;
            end
            branchCountQ     <= '0;
            mispredictCountQ <= '0;
        end else if (bus.UpdateE) begin
            validQ[idxE] <= 1'b1;
            tagQ[idxE]   <= tagE;
            cntQ[idxE]   <= cntNext;
            if (writeTarget) begin
                targetQ[idxE] <= bus.TargetE;
            end
            branchCountQ <= branchCountQ + 32'd1;
            if (bus.MispredictE) begin
                mispredictCountQ <= mispredictCountQ + 32'd1;
            end
        end
    end

    // PC bits outside the index/tag fields take no part in the lookup
    logic unusedPcBits;
    assign unusedPcBits = ^{bus.PCF[1:0], bus.PCF[31:TagHi+1], bus.PCE[1:0], bus.PCE[31:TagHi+1]};

endmodule

// File: tb/tb_branch_predictor_bht.sv
module tb_branch_predictor_bht;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    branch_predictor_bht_if bus ();

    branch_predictor_bht #(
        .IDX_W    (6),
        .TAG_W    (8),
        .CNT_INIT (2'b01)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [31:0] pcf, input logic upd, input logic [31:0] pce,
                         input logic tk, input logic [31:0] tgt, input logic misp);
        bus.PCF         = pcf;
        bus.UpdateE     = upd;
        bus.PCE         = pce;
        bus.TakenE      = tk;
        bus.TargetE     = tgt;
        bus.MispredictE = misp;
    endtask

    // Directed vectors: expected values are what is visible before the edge that applies the update
    typedef struct {
        logic [31:0] pcf;
        logic        upd;
        logic [31:0] pce;
        logic        tk;
        logic [31:0] tgt;
        logic        misp;
        logic        expTaken;
        logic [31:0] expTarget;
        int          expBc;
        int          expMc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [31:0] pcf, logic upd, logic [31:0] pce, logic tk,
                                logic [31:0] tgt, logic misp, logic eTk, logic [31:0] eTg,
                                int eBc, int eMc);
        vec_t v;
        v.pcf = pcf; v.upd = upd; v.pce = pce; v.tk = tk; v.tgt = tgt; v.misp = misp;
        v.expTaken = eTk; v.expTarget = eTg; v.expBc = eBc; v.expMc = eMc;
        return v;
    endfunction

    // Behavioural reference: entry strength 0..3, predicts taken at strength >= 2
    typedef struct {
        bit          valid;
        int unsigned tag;
        int unsigned target;
        int          strength;
    } entry_t;

    entry_t      model[64];
    int unsigned mBranch;
    int unsigned mMisp;

    function automatic int unsigned idxOf(logic [31:0] pc);
        return (int'(pc) / 4) % 64;
    endfunction

    function automatic int unsigned tagOf(logic [31:0] pc);
        return (pc / 256) % 256;
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < 64; i++) begin
            model[i] = '{valid: 1'b0, tag: 0, target: 0, strength: 1};
        end
        mBranch = 0;
        mMisp   = 0;
    endfunction

    function automatic void modelPredict(input logic [31:0] pc, output logic tk,
                                         output logic [31:0] tg);
        entry_t e = model[(pc / 4) % 64];
        tk = 1'b0;
        tg = 32'h0;
        if (e.valid && e.tag == tagOf(pc)) begin
            tk = (e.strength >= 2);
            tg = e.target;
        end
    endfunction

    function automatic void modelUpdate(input logic [31:0] pc, input logic tk,
                                        input logic [31:0] tgt, input logic misp);
        int unsigned i = (pc / 4) % 64;
        mBranch++;
        if (misp) mMisp++;
        if (model[i].valid && model[i].tag == tagOf(pc)) begin
            if (tk) begin
                model[i].strength = (model[i].strength + 1 > 3) ? 3 : model[i].strength + 1;
                model[i].target   = tgt;
            end else begin
                model[i].strength = (model[i].strength - 1 < 0) ? 0 : model[i].strength - 1;
            end
        end else begin
            model[i] = '{valid: 1'b1, tag: tagOf(pc), target: tgt, strength: tk ? 2 : 1};
        end
    endfunction

    initial begin
        logic        eTk;
        logic [31:0] eTg;

        rst = 1'b1;
        drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_taken", {31'b0, bus.PredictTakenF}, 32'h0);
        check("reset_target", bus.PredictTargetF, 32'h0);
        check("reset_bc", bus.BranchCount, 32'h0);
        check("reset_mc", bus.MispredictCount, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        //          pcf        upd  pce          tk   tgt          misp eTk  eTg       bc  mc
        vecs.push_back(mk(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 0, 0));
        vecs.push_back(mk(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 1'b0, 32'h0, 0, 0));
        vecs.push_back(mk(32'h100, 1'b1, 32'h100, 1'b0, 32'h999, 1'b0, 1'b1, 32'h80, 1, 1));
        vecs.push_back(mk(32'h100, 1'b1, 32'h100, 1'b0, 32'h999, 1'b0, 1'b0, 32'h80, 2, 1));
        vecs.push_back(mk(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 1'b0, 32'h80, 3, 1));
        vecs.push_back(mk(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 32'h80, 4, 2));
        vecs.push_back(mk(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 1'b1, 32'h80, 5, 2));
        vecs.push_back(mk(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 1'b1, 32'h80, 6, 2));
        vecs.push_back(mk(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 1'b1, 32'h80, 7, 2));
        vecs.push_back(mk(32'h100, 1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 1'b1, 32'h80, 8, 2));
        // UpdateE=0 with live-looking E inputs must change nothing
        vecs.push_back(mk(32'h100, 1'b0, 32'h100, 1'b0, 32'h5, 1'b1, 1'b1, 32'h80, 9, 3));
        vecs.push_back(mk(32'h100, 1'b0, 32'h100, 1'b0, 32'h5, 1'b1, 1'b1, 32'h80, 9, 3));
        // Alias: same idx, different tag
        vecs.push_back(mk(32'h200, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 9, 3));
        vecs.push_back(mk(32'h200, 1'b1, 32'h200, 1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 9, 3));
        vecs.push_back(mk(32'h200, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 10, 4));
        vecs.push_back(mk(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 10, 4));
        // Same-cycle lookup and update on an empty entry: no bypass
        vecs.push_back(mk(32'h304, 1'b1, 32'h304, 1'b1, 32'h1234, 1'b0, 1'b0, 32'h0, 10, 4));
        vecs.push_back(mk(32'h304, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1234, 11, 4));
        // Bits above the tag are ignored: shares the entry
        vecs.push_back(mk(32'h10307, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1234, 11, 4));
        // Not-taken miss allocates WNT with the given target
        vecs.push_back(mk(32'h508, 1'b1, 32'h508, 1'b0, 32'h55, 1'b0, 1'b0, 32'h0, 11, 4));
        vecs.push_back(mk(32'h508, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h55, 12, 4));

        foreach (vecs[n]) begin
            @(negedge clk);
            drive(vecs[n].pcf, vecs[n].upd, vecs[n].pce, vecs[n].tk, vecs[n].tgt, vecs[n].misp);
            #1;
            check($sformatf("vec%0d_taken", n), {31'b0, bus.PredictTakenF},
                  {31'b0, vecs[n].expTaken});
            check($sformatf("vec%0d_target", n), bus.PredictTargetF, vecs[n].expTarget);
            check($sformatf("vec%0d_bc", n), bus.BranchCount, vecs[n].expBc);
            check($sformatf("vec%0d_mc", n), bus.MispredictCount, vecs[n].expMc);
        end

        // Asynchronous reset mid-cycle, with an update offered while held
        @(negedge clk);
        drive(32'h304, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #2;
        rst = 1'b1;
        drive(32'h304, 1'b1, 32'h608, 1'b1, 32'h66, 1'b1);
        #1;
        check("async_rst_taken", {31'b0, bus.PredictTakenF}, 32'h0);
        check("async_rst_target", bus.PredictTargetF, 32'h0);
        check("async_rst_bc", bus.BranchCount, 32'h0);
        check("async_rst_mc", bus.MispredictCount, 32'h0);
        @(posedge clk);
        #1;
        bus.PCF = 32'h608;
        #1;
        check("rst_drop_taken", {31'b0, bus.PredictTakenF}, 32'h0);
        check("rst_drop_target", bus.PredictTargetF, 32'h0);
        check("rst_drop_bc", bus.BranchCount, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(32'h100, 1'b1, 32'h70c, 1'b1, 32'h77, 1'b0);
        #1;
        check("post_rst_miss_taken", {31'b0, bus.PredictTakenF}, 32'h0);
        check("post_rst_miss_target", bus.PredictTargetF, 32'h0);
        @(posedge clk);
        #1;
        drive(32'h70c, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        check("first_upd_taken", {31'b0, bus.PredictTakenF}, 32'h1);
        check("first_upd_target", bus.PredictTargetF, 32'h77);
        check("first_upd_bc", bus.BranchCount, 32'h1);
        check("first_upd_mc", bus.MispredictCount, 32'h0);

        // Randomized phase against the reference model, starting from a fresh reset
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        modelReset();
        for (int i = 0; i < 400; i++) begin
            logic [31:0] pcf;
            logic [31:0] pce;
            @(negedge clk);
            // Small idx/tag pool so hits, training and aliasing all occur often
            pcf = {$urandom_range(0, 3) == 0 ? 16'($urandom) : 16'h0,
                   8'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            pce = {$urandom_range(0, 3) == 0 ? 16'($urandom) : 16'h0,
                   8'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            drive(pcf, 1'($urandom_range(0, 2) != 0), pce, 1'($urandom), $urandom, 1'($urandom));
            #1;
            modelPredict(pcf, eTk, eTg);
            check("rand_taken", {31'b0, bus.PredictTakenF}, {31'b0, eTk});
            check("rand_target", bus.PredictTargetF, eTg);
            check("rand_bc", bus.BranchCount, mBranch);
            check("rand_mc", bus.MispredictCount, mMisp);
            @(posedge clk);
            if (bus.UpdateE) modelUpdate(bus.PCE, bus.TakenE, bus.TargetE, bus.MispredictE);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
